// File: rtl/lsu_agu_if.sv
// Issue-side and output-side handshake bundle for the LSU address-generation stage.
// The master drives requests and output backpressure; the slave is the AGU itself.
interface lsu_agu_if #(
  parameter int XLEN               = 64,
  parameter int VIRTUAL_ADDR_LEN   = 39,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int IMM_LEN            = 12
);
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic                          req_opcode_i;
  logic [1:0]                    req_size_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] req_rd_addr_i;
  logic [XLEN-1:0]               req_base_i;
  logic [IMM_LEN-1:0]            req_imm_i;
  logic [XLEN-1:0]               req_store_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic                          out_opcode_o;
  logic [1:0]                    out_size_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] out_rd_addr_o;
  logic [VIRTUAL_ADDR_LEN-1:0]   out_addr_o;
  logic [XLEN-1:0]               out_store_data_o;
  logic                          out_noncanon_o;

  modport master (
    output req_valid_i, req_opcode_i, req_size_i, req_rd_addr_i,
           req_base_i, req_imm_i, req_store_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_opcode_o, out_size_o,
           out_rd_addr_o, out_addr_o, out_store_data_o, out_noncanon_o
  );

  modport slave (
    input  req_valid_i, req_opcode_i, req_size_i, req_rd_addr_i,
           req_base_i, req_imm_i, req_store_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_opcode_o, out_size_o,
           out_rd_addr_o, out_addr_o, out_store_data_o, out_noncanon_o
  );
endinterface

// File: rtl/lsu_agu.sv
// LSU address-generation stage: vaddr = base + sext(imm), buffered in a 2-entry
// skid buffer so that the ready/valid handshake is fully registered.
module lsu_agu #(
  parameter int XLEN               = 64,
  parameter int VIRTUAL_ADDR_LEN   = 39,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int IMM_LEN            = 12
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  lsu_agu_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic                          opcode;
    logic [1:0]                    size;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
    logic [VIRTUAL_ADDR_LEN-1:0]   addr;
    logic [XLEN-1:0]               store_data;
    logic                          noncanon;
  } entry_t;

  // Address is non-canonical unless every bit above the VA sign bit copies it.
  function automatic logic noncanon_f(input logic [XLEN-1:0] sum);
    logic [XLEN-VIRTUAL_ADDR_LEN:0] hi;
    hi = sum[XLEN-1:VIRTUAL_ADDR_LEN-1];
    return !((hi == '0) || (hi == '1));
  endfunction

  state_e           state_r;
  logic             valid_r;
  logic             ready_r;
  entry_t           main_r;
  entry_t           skid_r;
  entry_t           new_s;
  logic [XLEN-1:0]  sum_s;
  logic             accept_s;
  logic             pop_s;

  // Handshake qualifiers and the freshly generated entry.
  always_comb begin
    accept_s         = bus.req_valid_i & ready_r;
    pop_s            = valid_r & bus.out_ready_i;
    sum_s            = bus.req_base_i +
                       {{(XLEN-IMM_LEN){bus.req_imm_i[IMM_LEN-1]}}, bus.req_imm_i};
    new_s.opcode     = bus.req_opcode_i;
    new_s.size       = bus.req_size_i;
    new_s.rd_addr    = bus.req_rd_addr_i;
    new_s.addr       = sum_s[VIRTUAL_ADDR_LEN-1:0];
    new_s.store_data = bus.req_store_data_i;
    new_s.noncanon   = noncanon_f(sum_s);
  end

  // Occupancy FSM; valid/ready are registered alongside the state so neither
  // depends combinationally on out_ready_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      main_r  <= '0;
      skid_r  <= '0;
    end else if (flush_i) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_r  <= new_s;
            state_r <= ST_ONE;
            valid_r <= 1'b1;
            ready_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            main_r <= new_s;
          end else if (accept_s) begin
            skid_r  <= new_s;
            state_r <= ST_TWO;
            ready_r <= 1'b0;
          end else if (pop_s) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            main_r  <= skid_r;
            state_r <= ST_ONE;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready_o      = ready_r;
  assign bus.out_valid_o      = valid_r;
  assign bus.out_opcode_o     = main_r.opcode;
  assign bus.out_size_o       = main_r.size;
  assign bus.out_rd_addr_o    = main_r.rd_addr;
  assign bus.out_addr_o       = main_r.addr;
  assign bus.out_store_data_o = main_r.store_data;
  assign bus.out_noncanon_o   = main_r.noncanon;

endmodule
